// File: rtl/continuous_monitoring_system_pkg.sv
// Shared types and constants for the continuous monitoring system.
// Holds the trace capture state encoding, config register offsets and
// CTRL register bit positions.
package continuous_monitoring_system_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } trace_ctrl_state_t;

    localparam int unsigned TRACE_CFG_ADDR_W = 2;
    localparam int unsigned TRACE_CFG_DATA_W = 64;

    localparam logic [TRACE_CFG_ADDR_W-1:0] TRACE_CTRL_ADDR_CTRL   = 2'd0;
    localparam logic [TRACE_CFG_ADDR_W-1:0] TRACE_CTRL_ADDR_START  = 2'd1;
    localparam logic [TRACE_CFG_ADDR_W-1:0] TRACE_CTRL_ADDR_STOP   = 2'd2;
    localparam logic [TRACE_CFG_ADDR_W-1:0] TRACE_CTRL_ADDR_BUDGET = 2'd3;

    localparam int unsigned TRACE_CTRL_BIT_ENABLE = 0;
    localparam int unsigned TRACE_CTRL_BIT_BYPASS = 1;
    localparam int unsigned TRACE_CTRL_BIT_CLEAR  = 2;

endpackage

// File: rtl/trace_capture_cfg_regs.sv
// Config register bank for the trace capture sequencer.
// Ports: clk/rst; cfg_we/cfg_addr/cfg_wdata host write port; state (current
// sequencer state, gates address/budget writes); enable, bypass, clear_pulse
// (one cycle, self-clearing), start_addr, stop_addr, budget.
module trace_capture_cfg_regs
    import continuous_monitoring_system_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = 64,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we,
    input  logic [TRACE_CFG_ADDR_W-1:0] cfg_addr,
    input  logic [TRACE_CFG_DATA_W-1:0] cfg_wdata,
    input  trace_ctrl_state_t           state,
    output logic                        enable,
    output logic                        bypass,
    output logic                        clear_pulse,
    output logic [PC_WIDTH-1:0]         start_addr,
    output logic [PC_WIDTH-1:0]         stop_addr,
    output logic [COUNT_WIDTH-1:0]      budget
);

    // Address and budget registers only change while the sequencer is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            enable      <= 1'b0;
            bypass      <= 1'b0;
            clear_pulse <= 1'b0;
            start_addr  <= '0;
            stop_addr   <= '0;
            budget      <= '0;
        end else begin
            clear_pulse <= 1'b0;
            if (cfg_we) begin
                case (cfg_addr)
                    TRACE_CTRL_ADDR_CTRL: begin
                        enable      <= cfg_wdata[TRACE_CTRL_BIT_ENABLE];
                        bypass      <= cfg_wdata[TRACE_CTRL_BIT_BYPASS];
                        clear_pulse <= cfg_wdata[TRACE_CTRL_BIT_CLEAR];
                    end
                    TRACE_CTRL_ADDR_START:
                        if (state == ST_IDLE) start_addr <= cfg_wdata[PC_WIDTH-1:0];
                    TRACE_CTRL_ADDR_STOP:
                        if (state == ST_IDLE) stop_addr <= cfg_wdata[PC_WIDTH-1:0];
                    TRACE_CTRL_ADDR_BUDGET:
                        if (state == ST_IDLE) budget <= cfg_wdata[COUNT_WIDTH-1:0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/trace_capture_ctrl.sv
// Run-control sequencer for the instruction-trace path: arms on a start PC,
// captures filter-kept instructions into a single-entry output register,
// stops on a stop PC or an accepted-item budget, and counts drops.
// Ports: clk/rst; cfg_* host write port; pc_valid/pc/drop_instr retire
// stream; trace_valid/trace_pc/trace_ready downstream handshake; state,
// items_captured, items_dropped, overflow, done status.
module trace_capture_ctrl
    import continuous_monitoring_system_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = 64,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we,
    input  logic [TRACE_CFG_ADDR_W-1:0] cfg_addr,
    input  logic [TRACE_CFG_DATA_W-1:0] cfg_wdata,
    input  logic                        pc_valid,
    input  logic [PC_WIDTH-1:0]         pc,
    input  logic                        drop_instr,
    output logic                        trace_valid,
    output logic [PC_WIDTH-1:0]         trace_pc,
    input  logic                        trace_ready,
    output logic [1:0]                  state,
    output logic [COUNT_WIDTH-1:0]      items_captured,
    output logic [COUNT_WIDTH-1:0]      items_dropped,
    output logic                        overflow,
    output logic                        done
);

    trace_ctrl_state_t          cur_state;
    trace_ctrl_state_t          nxt_state;
    logic                       enable;
    logic                       bypass;
    logic                       clear_pulse;
    logic [PC_WIDTH-1:0]        start_addr;
    logic [PC_WIDTH-1:0]        stop_addr;
    logic [COUNT_WIDTH-1:0]     budget;

    logic                       accept;
    logic                       start_hit;
    logic                       budget_hit;
    logic                       candidate;
    logic                       stop_hit;
    logic                       load;
    logic                       drop;
    logic [COUNT_WIDTH-1:0]     captured_plus;

    trace_capture_cfg_regs #(
        .PC_WIDTH    (PC_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_cfg (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .state       (cur_state),
        .enable      (enable),
        .bypass      (bypass),
        .clear_pulse (clear_pulse),
        .start_addr  (start_addr),
        .stop_addr   (stop_addr),
        .budget      (budget)
    );

    assign accept        = trace_valid && trace_ready;
    assign captured_plus = items_captured + COUNT_WIDTH'(accept && !(&items_captured));
    // Budget compares against the count including this cycle's accept, so the
    // sequencer leaves ACTIVE right after the last budgeted item is taken.
    assign budget_hit    = (budget != '0) && (captured_plus >= budget);
    assign start_hit     = (cur_state == ST_ARMED) && enable && pc_valid && (pc == start_addr);
    assign candidate     = enable && pc_valid && (bypass || !drop_instr) && !budget_hit &&
                           ((cur_state == ST_ACTIVE) || start_hit);
    assign stop_hit      = candidate && (pc == stop_addr);
    assign load          = candidate && (!trace_valid || accept);
    assign drop          = candidate && !load;

    // Next-state logic.
    always_comb begin
        nxt_state = cur_state;
        if (!enable) begin
            nxt_state = ST_IDLE;
        end else begin
            case (cur_state)
                ST_IDLE:   nxt_state = ST_ARMED;
                ST_ARMED:  if (start_hit) nxt_state = (stop_hit || budget_hit) ? ST_DONE : ST_ACTIVE;
                ST_ACTIVE: if (stop_hit || budget_hit) nxt_state = ST_DONE;
                ST_DONE:   nxt_state = ST_DONE;
                default:   nxt_state = ST_IDLE;
            endcase
        end
    end

    // State register, output item register and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state      <= ST_IDLE;
            done           <= 1'b0;
            trace_valid    <= 1'b0;
            trace_pc       <= '0;
            items_captured <= '0;
            items_dropped  <= '0;
            overflow       <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            done      <= (nxt_state == ST_DONE);

            // Disabling discards a pending item without counting it.
            if (!enable) begin
                trace_valid <= 1'b0;
            end else if (load) begin
                trace_valid <= 1'b1;
                trace_pc    <= pc;
            end else if (accept) begin
                trace_valid <= 1'b0;
            end

            // Clear has priority over same-cycle accept/drop accounting.
            if (clear_pulse) begin
                items_captured <= '0;
                items_dropped  <= '0;
                overflow       <= 1'b0;
            end else begin
                items_captured <= captured_plus;
                if (drop) begin
                    items_dropped <= items_dropped + COUNT_WIDTH'(!(&items_dropped));
                    overflow      <= 1'b1;
                end
            end
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Directed self-checking bench for trace_capture_ctrl.
module tb_trace_capture_ctrl;

    localparam int unsigned PW = 64;
    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [1:0]    cfg_addr;
    logic [63:0]   cfg_wdata;
    logic          pc_valid;
    logic [PW-1:0] pc;
    logic          drop_instr;
    logic          trace_valid;
    logic [PW-1:0] trace_pc;
    logic          trace_ready;
    logic [1:0]    state;
    logic [CW-1:0] items_captured;
    logic [CW-1:0] items_dropped;
    logic          overflow;
    logic          done;

    int n_checks = 0;
    int n_pass   = 0;

    trace_capture_ctrl #(.PC_WIDTH(PW), .COUNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .pc_valid       (pc_valid),
        .pc             (pc),
        .drop_instr     (drop_instr),
        .trace_valid    (trace_valid),
        .trace_pc       (trace_pc),
        .trace_ready    (trace_ready),
        .state          (state),
        .items_captured (items_captured),
        .items_dropped  (items_dropped),
        .overflow       (overflow),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [63:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic feed(input logic [63:0] a, input logic d);
        pc_valid   = 1'b1;
        pc         = a;
        drop_instr = d;
        tick();
    endtask

    task automatic idle_pc();
        pc_valid   = 1'b0;
        drop_instr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        pc_valid = 1'b0; pc = '0; drop_instr = 1'b0; trace_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_state",    64'(state), 64'd0);
        check("rst_valid",    64'(trace_valid), 64'd0);
        check("rst_pc",       trace_pc, 64'd0);
        check("rst_captured", 64'(items_captured), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);

        // Filtered capture window 0x1000..0x1010.
        cfg_write(2'd1, 64'h1000);
        cfg_write(2'd2, 64'h1010);
        cfg_write(2'd3, 64'd0);
        trace_ready = 1'b1;
        cfg_write(2'd0, 64'd1);
        tick();
        check("t1_armed", 64'(state), 64'd1);
        feed(64'h0FFC, 1'b1);
        check("t1_no_start", 64'(state), 64'd1);
        feed(64'h1000, 1'b0);
        check("t1_pc0", trace_pc, 64'h1000);
        check("t1_active", 64'(state), 64'd2);
        feed(64'h1004, 1'b1);
        check("t1_empty", 64'(trace_valid), 64'd0);
        feed(64'h1008, 1'b0);
        check("t1_pc1", trace_pc, 64'h1008);
        feed(64'h100C, 1'b1);
        feed(64'h1010, 1'b0);
        check("t1_pc2", trace_pc, 64'h1010);
        check("t1_done_state", 64'(state), 64'd3);
        feed(64'h1014, 1'b1);
        idle_pc();
        check("t1_captured", 64'(items_captured), 64'd3);
        check("t1_done", 64'(done), 64'd1);

        // Disable with clear, then same window with bypass.
        cfg_write(2'd0, 64'd4);
        tick();
        check("t2_idle", 64'(state), 64'd0);
        check("t2_cleared", 64'(items_captured), 64'd0);
        cfg_write(2'd0, 64'd3);
        tick();
        feed(64'h0FFC, 1'b1);
        for (int i = 0; i < 5; i++) begin
            feed(64'h1000 + 64'(4 * i), 1'b1);
            check("t2_pc", trace_pc, 64'h1000 + 64'(4 * i));
        end
        feed(64'h1014, 1'b1);
        idle_pc();
        check("t2_captured", 64'(items_captured), 64'd5);
        check("t2_state", 64'(state), 64'd3);

        // Budget of two accepted items.
        cfg_write(2'd0, 64'd4);
        tick();
        cfg_write(2'd3, 64'd2);
        cfg_write(2'd0, 64'd3);
        tick();
        feed(64'h1000, 1'b0);
        feed(64'h2000, 1'b0);
        check("t3_cap1", 64'(items_captured), 64'd1);
        check("t3_still_active", 64'(state), 64'd2);
        feed(64'h2004, 1'b0);
        check("t3_cap2", 64'(items_captured), 64'd2);
        check("t3_done_next", 64'(state), 64'd3);
        feed(64'h2008, 1'b0);
        feed(64'h200C, 1'b0);
        idle_pc();
        check("t3_cap_final", 64'(items_captured), 64'd2);
        check("t3_no_item", 64'(trace_valid), 64'd0);

        // Backpressure: three candidates with ready low.
        cfg_write(2'd0, 64'd4);
        tick();
        cfg_write(2'd3, 64'd0);
        trace_ready = 1'b0;
        cfg_write(2'd0, 64'd3);
        tick();
        feed(64'h1000, 1'b0);
        feed(64'h3000, 1'b0);
        feed(64'h3004, 1'b0);
        idle_pc();
        check("t4_held_pc", trace_pc, 64'h1000);
        check("t4_held_valid", 64'(trace_valid), 64'd1);
        check("t4_dropped", 64'(items_dropped), 64'd2);
        check("t4_overflow", 64'(overflow), 64'd1);
        trace_ready = 1'b1;
        tick();
        check("t4_captured", 64'(items_captured), 64'd1);

        // Disable with a pending item.
        trace_ready = 1'b0;
        feed(64'h3008, 1'b0);
        idle_pc();
        check("t5_pending", trace_pc, 64'h3008);
        cfg_write(2'd0, 64'd0);
        tick();
        check("t5_idle", 64'(state), 64'd0);
        check("t5_discarded", 64'(trace_valid), 64'd0);
        check("t5_cap_same", 64'(items_captured), 64'd1);

        // START write while ARMED is ignored.
        cfg_write(2'd0, 64'd1);
        tick();
        cfg_write(2'd1, 64'h5000);
        feed(64'h5000, 1'b0);
        check("t5_no_trigger", 64'(state), 64'd1);
        feed(64'h1000, 1'b0);
        idle_pc();
        check("t5_old_start", 64'(state), 64'd2);
        check("t5_old_pc", trace_pc, 64'h1000);

        // Reset while ACTIVE.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_state",   64'(state), 64'd0);
        check("t6_rst_valid",   64'(trace_valid), 64'd0);
        check("t6_rst_pc",      trace_pc, 64'd0);
        check("t6_rst_cap",     64'(items_captured), 64'd0);
        check("t6_rst_drop",    64'(items_dropped), 64'd0);
        check("t6_rst_ovf",     64'(overflow), 64'd0);
        check("t6_rst_done",    64'(done), 64'd0);

        // Clear coinciding with an accept.
        cfg_write(2'd1, 64'h1000);
        cfg_write(2'd2, 64'h1010);
        cfg_write(2'd0, 64'd3);
        tick();
        feed(64'h1000, 1'b0);
        idle_pc();
        cfg_write(2'd0, 64'd7);
        trace_ready = 1'b1;
        feed(64'h1004, 1'b0);
        idle_pc();
        check("t6_clear_wins", 64'(items_captured), 64'd0);
        check("t6_reload_pc", trace_pc, 64'h1004);
        tick();
        check("t6_count_resumes", 64'(items_captured), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/trace_capture_ctrl.md
Name: trace_capture_ctrl

Overview:
Run-control sequencer for the instruction-trace path of the continuous monitoring system. It arms on a start PC, captures trace items while the trace filter marks instructions as kept, and stops on a stop PC or when a capture budget is exhausted. Downstream it pushes items into the trace FIFO with a valid/ready handshake and accounts for items dropped under backpressure. It is configured through a small register write port driven by the host interface.

Parameters:
PC_WIDTH, 64, width of program counter and address registers
COUNT_WIDTH, 32, width of budget, captured and dropped counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cfg_we  in  1  config write strobe
cfg_addr  in  2  0=CTRL, 1=START_ADDR, 2=STOP_ADDR, 3=BUDGET
cfg_wdata  in  64  write data (low COUNT_WIDTH bits used for BUDGET)
pc_valid  in  1  pc/drop_instr valid this cycle
pc  in  PC_WIDTH  retiring instruction address
drop_instr  in  1  filter verdict, aligned with pc in the same cycle
trace_valid  out  1  trace item available
trace_pc  out  PC_WIDTH  captured address
trace_ready  in  1  downstream FIFO can accept
state  out  2  current state encoding
items_captured  out  COUNT_WIDTH  items accepted downstream
items_dropped  out  COUNT_WIDTH  items lost to backpressure
overflow  out  1  sticky; set on first drop
done  out  1  high while in DONE

Behaviour:
- Reset: state=IDLE; trace_valid=0; trace_pc=0; counters=0; overflow=0; done=0. All config registers are 0.
- CTRL bits:
  - [0] enable
  - [1] bypass: ignore drop_instr and capture every valid pc
  - [2] clear: self-clearing, zeroes counters and overflow
- START_ADDR, STOP_ADDR and BUDGET writes are accepted only in IDLE; in other states they are ignored. CTRL writes are accepted in any state. A write takes effect the cycle after cfg_we.
- States: IDLE=0, ARMED=1, ACTIVE=2, DONE=3.
  - IDLE -> ARMED when enable=1.
  - ARMED -> ACTIVE on pc_valid && pc==START_ADDR. The start instruction is a capture candidate in that same cycle.
  - ACTIVE -> DONE on a candidate with pc==STOP_ADDR; that instruction is still captured. ACTIVE -> DONE also when items_captured reaches a nonzero BUDGET (BUDGET=0 means unlimited).
  - DONE holds until enable=0.
  - From any state, enable=0 -> IDLE next cycle. A pending output item is discarded and not counted.
- Candidate: pc_valid && (bypass || !drop_instr) while ACTIVE, or on the ARMED->ACTIVE transition cycle.
- Output register, single entry, latency 1:
  - A candidate loads trace_pc and sets trace_valid if the register is empty or being accepted this cycle (trace_valid && trace_ready).
  - Otherwise the candidate is dropped: items_dropped++ (saturating) and overflow is set.
- Handshake: trace_valid and trace_pc stay stable until trace_ready. Each accept increments items_captured (saturating).
- The budget check uses accepted items. While in DONE, a held item is still delivered; no new candidates are taken.
- START_ADDR==STOP_ADDR: the first hit captures one item and goes directly to DONE.
- A clear write on the same cycle as an accept or drop: the clear wins and the counters read 0.

Decomposition:
- Package continuous_monitoring_system_pkg gets:
  - typedef enum logic[1:0] trace_ctrl_state_t
  - register offsets TRACE_CTRL_ADDR_CTRL, _START, _STOP, _BUDGET
  - CTRL bit index constants
- Sub-module trace_capture_cfg_regs: the register bank with IDLE-only write gating. Its outputs are enable, bypass, clear_pulse, start_addr, stop_addr and budget.

Test Plan:
- START=0x1000, STOP=0x1010, budget 0, ready=1. Feed pc 0x0FFC..0x1014 step 4 with drop_instr=0 at 0x1000, 0x1008, 0x1010 -> trace_pc 0x1000, 0x1008, 0x1010; captured=3; state=DONE; done=1.
- Same setup with bypass=1 -> 5 items, 0x1000..0x1010.
- BUDGET=2, bypass=1, start hit, then 4 valid pcs -> captured=2; DONE entered the cycle after the second accept.
- Hold trace_ready=0 with 3 back-to-back candidates -> first item held stable, dropped=2, overflow=1. Release ready -> captured=1.
- enable=0 in ACTIVE with trace_valid pending -> IDLE next cycle, trace_valid=0, captured unchanged. Write START during ARMED -> value unchanged on readback of behaviour (no trigger at the new address).
- Assert rst mid-ACTIVE -> all outputs return to reset values next cycle. A clear write coinciding with an accept -> counters read 0.
